// File: rtl/root_power_arbiter_if.sv
// Request/grant and select buses between the NTT/INTT engines, the root-power arbiter
// and the root-power interconnect.
interface root_power_arbiter_if #(
  parameter int unsigned NTT_INTT_NUM   = 4,
  parameter int unsigned ROOT_POWER_NUM = 4,
  parameter int unsigned LEN_W          = 8
);
  localparam int unsigned EngW  = (NTT_INTT_NUM > 1) ? $clog2(NTT_INTT_NUM) : 1;
  localparam int unsigned BankW = (ROOT_POWER_NUM > 1) ? $clog2(ROOT_POWER_NUM) : 1;

  logic [NTT_INTT_NUM-1:0]                 req;
  logic [NTT_INTT_NUM-1:0][BankW-1:0]      req_bank;
  logic [NTT_INTT_NUM-1:0][LEN_W-1:0]      req_len;
  logic [NTT_INTT_NUM-1:0]                 gnt;
  logic [NTT_INTT_NUM-1:0]                 beat_en;
  logic [ROOT_POWER_NUM-1:0][EngW-1:0]     ntt_intt_select;
  logic [ROOT_POWER_NUM-1:0]               bank_busy;
  logic [NTT_INTT_NUM-1:0][BankW-1:0]      root_select;
  logic [NTT_INTT_NUM-1:0]                 rd_valid;

  modport master (
    output req, req_bank, req_len,
    input  gnt, beat_en, ntt_intt_select, bank_busy, root_select, rd_valid
  );

  modport slave (
    input  req, req_bank, req_len,
    output gnt, beat_en, ntt_intt_select, bank_busy, root_select, rd_valid
  );
endinterface

// File: rtl/root_power_arbiter.sv
// Per-bank round-robin burst arbiter for the twiddle RAM banks; engine-side valids and
// bank selects are delayed to line up with returning read data.
module root_power_arbiter #(
  parameter int unsigned NTT_INTT_NUM   = 4,
  parameter int unsigned ROOT_POWER_NUM = 4,
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned RET_DLY        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  root_power_arbiter_if.slave   arb
);
  localparam int unsigned EngW  = (NTT_INTT_NUM > 1) ? $clog2(NTT_INTT_NUM) : 1;
  localparam int unsigned BankW = (ROOT_POWER_NUM > 1) ? $clog2(ROOT_POWER_NUM) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                               state_q   [ROOT_POWER_NUM];
  state_e                               state_d   [ROOT_POWER_NUM];
  logic [EngW-1:0]                      owner_q   [ROOT_POWER_NUM];
  logic [EngW-1:0]                      owner_d   [ROOT_POWER_NUM];
  logic [LEN_W-1:0]                     cnt_q     [ROOT_POWER_NUM];
  logic [LEN_W-1:0]                     cnt_d     [ROOT_POWER_NUM];
  logic [EngW-1:0]                      rr_q      [ROOT_POWER_NUM];
  logic [EngW-1:0]                      rr_d      [ROOT_POWER_NUM];
  logic [NTT_INTT_NUM-1:0]              elig      [ROOT_POWER_NUM];
  logic [EngW-1:0]                      pick      [ROOT_POWER_NUM];
  logic [ROOT_POWER_NUM-1:0]            found;

  logic [NTT_INTT_NUM-1:0]              gnt_q, gnt_d;
  logic [NTT_INTT_NUM-1:0]              beat_en_q, beat_en_d;
  logic [BankW-1:0]                     eng_bank_q [NTT_INTT_NUM];
  logic [BankW-1:0]                     eng_bank_d [NTT_INTT_NUM];

  logic [NTT_INTT_NUM-1:0]              vld_q [RET_DLY];
  logic [NTT_INTT_NUM-1:0]              vld_d [RET_DLY];
  logic [NTT_INTT_NUM-1:0][BankW-1:0]   bnk_q [RET_DLY];
  logic [NTT_INTT_NUM-1:0][BankW-1:0]   bnk_d [RET_DLY];

  // An engine already issuing beats cannot hold a second burst, on any bank.
  always_comb begin
    for (int b = 0; b < ROOT_POWER_NUM; b++) begin
      for (int r = 0; r < NTT_INTT_NUM; r++) begin
        elig[b][r] = arb.req[r] && (arb.req_bank[r] == BankW'(b)) && !beat_en_q[r];
      end
    end
  end

  always_comb begin : p_pick
    int unsigned idx;
    idx   = 0;
    found = '0;
    for (int b = 0; b < ROOT_POWER_NUM; b++) begin
      pick[b] = '0;
      for (int i = 0; i < NTT_INTT_NUM; i++) begin
        idx = (int'(rr_q[b]) + i) % NTT_INTT_NUM;
        if (!found[b] && elig[b][idx]) begin
          found[b] = 1'b1;
          pick[b]  = EngW'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    beat_en_d  = '0;
    eng_bank_d = eng_bank_q;
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    for (int b = 0; b < ROOT_POWER_NUM; b++) begin
      if ((state_q[b] == StBurst) && (cnt_q[b] != '0)) begin
        cnt_d[b] = cnt_q[b] - 1'b1;
      end else if (found[b]) begin
        // Idle or last beat: the next burst starts on the following edge with no gap.
        state_d[b] = StBurst;
        owner_d[b] = pick[b];
        cnt_d[b]   = (arb.req_len[pick[b]] == '0) ? '0 : arb.req_len[pick[b]] - 1'b1;
        rr_d[b]    = (32'(pick[b]) == NTT_INTT_NUM - 1) ? '0 : pick[b] + 1'b1;
        gnt_d[pick[b]]      = 1'b1;
        eng_bank_d[pick[b]] = BankW'(b);
      end else begin
        state_d[b] = StIdle;
        cnt_d[b]   = '0;
      end
      if (state_d[b] == StBurst) begin
        beat_en_d[owner_d[b]] = 1'b1;
      end
    end
  end

  // Return path: bank tags only advance alongside a valid, so root_select holds when idle.
  always_comb begin
    vld_d[0] = beat_en_q;
    for (int r = 0; r < NTT_INTT_NUM; r++) begin
      bnk_d[0][r] = beat_en_q[r] ? eng_bank_q[r] : bnk_q[0][r];
    end
    for (int k = 1; k < RET_DLY; k++) begin
      vld_d[k] = vld_q[k-1];
      for (int r = 0; r < NTT_INTT_NUM; r++) begin
        bnk_d[k][r] = vld_q[k-1][r] ? bnk_q[k-1][r] : bnk_q[k][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      beat_en_q <= '0;
      for (int b = 0; b < ROOT_POWER_NUM; b++) begin
        state_q[b] <= StIdle;
        owner_q[b] <= '0;
        cnt_q[b]   <= '0;
        rr_q[b]    <= '0;
      end
      for (int r = 0; r < NTT_INTT_NUM; r++) begin
        eng_bank_q[r] <= '0;
      end
      for (int k = 0; k < RET_DLY; k++) begin
        vld_q[k] <= '0;
        bnk_q[k] <= '0;
      end
    end else begin
      gnt_q      <= gnt_d;
      beat_en_q  <= beat_en_d;
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      eng_bank_q <= eng_bank_d;
      vld_q      <= vld_d;
      bnk_q      <= bnk_d;
    end
  end

  always_comb begin
    arb.gnt         = gnt_q;
    arb.beat_en     = beat_en_q;
    arb.rd_valid    = vld_q[RET_DLY-1];
    arb.root_select = bnk_q[RET_DLY-1];
    for (int b = 0; b < ROOT_POWER_NUM; b++) begin
      arb.ntt_intt_select[b] = owner_q[b];
      arb.bank_busy[b]       = (state_q[b] == StBurst);
    end
  end

endmodule

// File: tb/tb_root_power_arbiter.sv
// Directed bench for root_power_arbiter: single burst, round-robin chain, parallel banks,
// zero-length burst and mid-burst reset.
module tb_root_power_arbiter;
  localparam int unsigned N     = 4;
  localparam int unsigned B     = 4;
  localparam int unsigned LW    = 8;
  localparam int unsigned DLY   = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  root_power_arbiter_if #(.NTT_INTT_NUM(N), .ROOT_POWER_NUM(B), .LEN_W(LW)) arb_bus ();

  root_power_arbiter #(
    .NTT_INTT_NUM  (N),
    .ROOT_POWER_NUM(B),
    .LEN_W         (LW),
    .RET_DLY       (DLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(arb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " gnt"},      32'(arb_bus.gnt), 32'h0);
    check_eq({tag, " beat_en"},  32'(arb_bus.beat_en), 32'h0);
    check_eq({tag, " busy"},     32'(arb_bus.bank_busy), 32'h0);
    check_eq({tag, " nsel"},     32'(arb_bus.ntt_intt_select), 32'h0);
    check_eq({tag, " rd_valid"}, 32'(arb_bus.rd_valid), 32'h0);
    check_eq({tag, " rsel"},     32'(arb_bus.root_select), 32'h0);
  endtask

  logic [3:0] exp_g;
  logic [3:0] exp_be;
  int         busy_cycles;
  int         be_cycles;
  int         rv_cycles;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst   = 1'b1;
    arb_bus.req      = '0;
    arb_bus.req_bank = '0;
    arb_bus.req_len  = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // 1: engine 0 -> bank 2, len 3
    arb_bus.req_bank[0] = 2'd2;
    arb_bus.req_len[0]  = 8'd3;
    arb_bus.req         = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin
        arb_bus.req = '0;
        check_eq("t1 gnt", 32'(arb_bus.gnt), 32'h1);
        check_eq("t1 nsel2", 32'(arb_bus.ntt_intt_select[2]), 32'h0);
        check_eq("t1 busy", 32'(arb_bus.bank_busy), 32'h4);
      end
      if (c == 2) check_eq("t1 gnt pulse", 32'(arb_bus.gnt), 32'h0);
      check_eq($sformatf("t1 beat_en c%0d", c), 32'(arb_bus.beat_en[0]),
               (c <= 3) ? 32'h1 : 32'h0);
      check_eq($sformatf("t1 rd_valid c%0d", c), 32'(arb_bus.rd_valid[0]),
               (c >= 5 && c <= 7) ? 32'h1 : 32'h0);
      if (c >= 5) check_eq($sformatf("t1 rsel c%0d", c), 32'(arb_bus.root_select[0]), 32'h2);
    end

    // 2: engines 0,1,3 -> bank 1, len 2; round-robin chain with no gaps
    arb_bus.req_bank[0] = 2'd1;
    arb_bus.req_bank[1] = 2'd1;
    arb_bus.req_bank[3] = 2'd1;
    arb_bus.req_len[0]  = 8'd2;
    arb_bus.req_len[1]  = 8'd2;
    arb_bus.req_len[3]  = 8'd2;
    arb_bus.req         = 4'b1011;
    busy_cycles = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      case (c)
        1:       exp_g = 4'b0001;
        3:       exp_g = 4'b0010;
        5:       exp_g = 4'b1000;
        default: exp_g = 4'b0000;
      endcase
      case (c)
        1, 2:    exp_be = 4'b0001;
        3, 4:    exp_be = 4'b0010;
        5, 6:    exp_be = 4'b1000;
        default: exp_be = 4'b0000;
      endcase
      check_eq($sformatf("t2 gnt c%0d", c), 32'(arb_bus.gnt), 32'(exp_g));
      check_eq($sformatf("t2 beat_en c%0d", c), 32'(arb_bus.beat_en), 32'(exp_be));
      if (c == 1) check_eq("t2 nsel1 c1", 32'(arb_bus.ntt_intt_select[1]), 32'h0);
      if (c == 3) check_eq("t2 nsel1 c3", 32'(arb_bus.ntt_intt_select[1]), 32'h1);
      if (c == 5) check_eq("t2 nsel1 c5", 32'(arb_bus.ntt_intt_select[1]), 32'h3);
      if (c == 7) check_eq("t2 nsel1 hold", 32'(arb_bus.ntt_intt_select[1]), 32'h3);
      if (arb_bus.bank_busy[1]) busy_cycles++;
      arb_bus.req = arb_bus.req & ~exp_g;
    end
    check_eq("t2 busy cycles", 32'(busy_cycles), 32'd6);
    arb_bus.req_len[0] = 8'd1;
    arb_bus.req        = 4'b0001;
    step();
    arb_bus.req = '0;
    check_eq("t2 rereq gnt", 32'(arb_bus.gnt), 32'h1);
    check_eq("t2 rereq nsel1", 32'(arb_bus.ntt_intt_select[1]), 32'h0);
    repeat (8) step();

    // 3: four engines to four distinct banks in the same cycle
    for (int r = 0; r < 4; r++) begin
      arb_bus.req_bank[r] = 2'(3 - r);
      arb_bus.req_len[r]  = 8'd1;
    end
    arb_bus.req = 4'b1111;
    step();
    arb_bus.req = '0;
    check_eq("t3 gnt", 32'(arb_bus.gnt), 32'hF);
    check_eq("t3 nsel", 32'(arb_bus.ntt_intt_select), 32'h1B);
    check_eq("t3 busy", 32'(arb_bus.bank_busy), 32'hF);
    step();
    check_eq("t3 beat_en end", 32'(arb_bus.beat_en), 32'h0);
    repeat (3) step();
    check_eq("t3 rd_valid", 32'(arb_bus.rd_valid), 32'hF);
    check_eq("t3 rsel", 32'(arb_bus.root_select), 32'h1B);
    repeat (4) step();

    // 4: zero length is one beat
    arb_bus.req_bank[2] = 2'd0;
    arb_bus.req_len[2]  = 8'd0;
    arb_bus.req         = 4'b0100;
    be_cycles = 0;
    rv_cycles = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        arb_bus.req = '0;
        check_eq("t4 gnt", 32'(arb_bus.gnt), 32'h4);
      end
      if (c == 5) check_eq("t4 rd_valid c5", 32'(arb_bus.rd_valid), 32'h4);
      if (arb_bus.beat_en[2]) be_cycles++;
      if (arb_bus.rd_valid[2]) rv_cycles++;
    end
    check_eq("t4 beat count", 32'(be_cycles), 32'd1);
    check_eq("t4 valid count", 32'(rv_cycles), 32'd1);

    // 5: reset during the second beat of a len-8 burst
    arb_bus.req_bank[1] = 2'd3;
    arb_bus.req_len[1]  = 8'd8;
    arb_bus.req         = 4'b0010;
    step();
    arb_bus.req = '0;
    check_eq("t5 gnt", 32'(arb_bus.gnt), 32'h2);
    step();
    check_eq("t5 beat2", 32'(arb_bus.beat_en), 32'h2);
    rst = 1'b1;
    step();
    check_all_zero("t5 after rst");
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_eq($sformatf("t5 no rd_valid c%0d", c), 32'(arb_bus.rd_valid), 32'h0);
    end
    // rr_ptr back at 0 means engine 1 beats engine 3
    arb_bus.req_bank[3] = 2'd3;
    arb_bus.req_len[1]  = 8'd1;
    arb_bus.req_len[3]  = 8'd1;
    arb_bus.req         = 4'b1010;
    step();
    check_eq("t5 rereq gnt", 32'(arb_bus.gnt), 32'h2);
    check_eq("t5 rereq nsel3", 32'(arb_bus.ntt_intt_select[3]), 32'h1);
    arb_bus.req = '0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
